// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths, frame FSM state type and data-bit extraction for the Hamming(15,11) decoder
package hamming_pkg;
  localparam int CODE_W = 15;
  localparam int DATA_W = 11;
  localparam int SYN_W  = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT} state_e;
  // Data bits live at the non-power-of-two positions; highest position lands in the MSB.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
    return {c[14:8], c[6:4], c[2]};
  endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational Hamming(15,11) syndrome; code_i bit i is position i+1, syn_o = {p8,p4,p2,p1}
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syn_o
);
  always_comb begin
    syn_o = '0;
    for (int i = 0; i < CODE_W; i++)
      for (int k = 0; k < SYN_W; k++)
        if (((i + 1) & (1 << k)) != 0) syn_o[k] = syn_o[k] ^ code_i[i];
  end
endmodule

// File: rtl/hamming_stream_decoder.sv
// hamming_stream_decoder: two-stage streaming Hamming(15,11) decoder with per-frame corrected-word count
// Ports: clk, rst_n (async, active low), clear (sync flush); in_valid/in_ready/in_code input stream;
//   out_valid/out_ready/out_data/out_corrected output stream; frame_done pulse and frame_err_cnt report.
// Option: define HAMMING_ERR_INJECT_EN to add inj_en/inj_pos, which flip one bit of an accepted word.
module hamming_stream_decoder
  import hamming_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [3:0]        inj_pos,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrected,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_err_cnt
);
  localparam int WC_W = $clog2(FRAME_LEN + 1);
  localparam logic [WC_W-1:0] FL = WC_W'(FRAME_LEN);
  logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d, s2_corr_q;
  logic [CODE_W-1:0] s1_code_q, code_in, fixed;
  logic [SYN_W-1:0]  s1_syn_q, syn_in;
  logic [DATA_W-1:0] s2_data_q;
  state_e            state_q;
  logic [WC_W-1:0]   word_cnt_q, word_nxt;
  logic [CNT_W-1:0]  err_cnt_q, err_nxt, frame_err_cnt_q;
  logic              hs, s1_move, acc, last;
`ifdef HAMMING_ERR_INJECT_EN
  assign code_in = in_code ^ ((inj_en && inj_pos != '0) ? (CODE_W'(1) << (inj_pos - 4'd1)) : '0);
`else
  assign code_in = in_code;
`endif
  hamming_syndrome u_syn (.code_i(code_in), .syn_o(syn_in));
  // The report cycle hides S2 so no handshake can land while the frame result is published.
  assign out_valid     = s2_v_q & (state_q != ST_REPORT);
  assign hs            = out_valid & out_ready;
  assign s1_move       = s1_v_q & (!s2_v_q | hs);
  assign in_ready      = !s1_v_q | s1_move;
  assign acc           = in_valid & in_ready;
  assign s1_v_d        = acc | (s1_v_q & !s1_move);
  assign s2_v_d        = s1_move | (s2_v_q & !hs);
  assign fixed         = s1_code_q ^ ((s1_syn_q != '0) ? (CODE_W'(1) << (s1_syn_q - 4'd1)) : '0);
  assign out_data      = s2_data_q;
  assign out_corrected = s2_corr_q;
  assign frame_done    = state_q == ST_REPORT;
  assign frame_err_cnt = frame_err_cnt_q;
  assign word_nxt      = word_cnt_q + WC_W'(1);
  assign last          = word_nxt == FL;
  assign err_nxt       = err_cnt_q + CNT_W'(s2_corr_q & (err_cnt_q != '1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_code_q <= '0;
      s1_syn_q  <= '0;
      s2_data_q <= '0;
      s2_corr_q <= 1'b0;
    end else if (clear) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s1_code_q <= '0;
      s1_syn_q  <= '0;
      s2_data_q <= '0;
      s2_corr_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (acc) begin
        s1_code_q <= code_in;
        s1_syn_q  <= syn_in;
      end
      if (s1_move) begin
        s2_data_q <= extract_data(fixed);
        s2_corr_q <= s1_syn_q != '0;
      end
    end
  end
  // The frame result is latched on the closing handshake so it is already valid during the frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      word_cnt_q      <= '0;
      err_cnt_q       <= '0;
      frame_err_cnt_q <= '0;
    end else if (clear) begin
      state_q         <= ST_IDLE;
      word_cnt_q      <= '0;
      err_cnt_q       <= '0;
      frame_err_cnt_q <= '0;
    end else if (state_q == ST_REPORT) begin
      state_q <= ST_IDLE;
    end else if (hs) begin
      state_q    <= last ? ST_REPORT : ST_RUN;
      word_cnt_q <= last ? '0 : word_nxt;
      err_cnt_q  <= last ? '0 : err_nxt;
      if (last) frame_err_cnt_q <= err_nxt;
    end
  end
endmodule

// File: tb/tb_hamming_stream_decoder.sv
// tb_hamming_stream_decoder: randomized self-checking bench against an encoder-based reference model
module tb_hamming_stream_decoder;
  localparam int FL = 4;
  localparam int CW = 2;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [14:0] in_code = '0;
  logic in_ready, out_valid, out_corrected, frame_done;
  logic [10:0] out_data;
  logic [CW-1:0] frame_err_cnt;
`ifdef HAMMING_ERR_INJECT_EN
  logic inj_en = 1'b0;
  logic [3:0] inj_pos = '0;
`endif
  hamming_stream_decoder #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_en(inj_en), .inj_pos(inj_pos),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corrected(out_corrected), .frame_done(frame_done), .frame_err_cnt(frame_err_cnt)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [10:0] exp_d[$], got_d[$];
  logic exp_c[$], got_c[$];
  logic [CW-1:0] fcnt_q[$];
  logic fd_prev = 1'b0, ir_seen = 1'b0;
  int fd_n = 0, fd_ov_bad = 0;
  // Reference encoder: data bits fill non-power-of-two positions in ascending order, parities make each group even.
  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 15; p++) if ((p & (p - 1)) != 0) begin c[p-1] = d[j]; j++; end
    for (int k = 0; k < 4; k++)
      for (int p = 1; p <= 15; p++)
        if (((p >> k) & 1) == 1 && p != (1 << k)) c[(1<<k)-1] = c[(1<<k)-1] ^ c[p-1];
    return c;
  endfunction
  function automatic void rand_word(input bit force_err, output logic [14:0] c, output logic [10:0] d, output logic e);
    int p;
    d = 11'($urandom);
    c = encode(d);
    p = force_err ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 15));
    if (p != 0) c[p-1] = ~c[p-1];
    e = p != 0;
  endfunction
  // One clock: drive at the falling edge, log accepts and handshakes, observe again at the next falling edge.
  task automatic tick(input logic iv, input logic [14:0] code, input logic [10:0] ed, input logic ec, input logic ordy, output logic acc);
    out_ready = ordy;
    in_valid = iv;
    in_code = code;
    #1;
    ir_seen = in_ready;
    acc = iv & in_ready;
    if (acc) begin exp_d.push_back(ed); exp_c.push_back(ec); end
    if (out_valid && out_ready) begin got_d.push_back(out_data); got_c.push_back(out_corrected); end
    @(posedge clk);
    @(negedge clk);
    if (fd_prev) fcnt_q.push_back(frame_err_cnt);
    fd_prev = frame_done;
    if (frame_done) begin fd_n++; if (out_valid) fd_ov_bad++; end
  endtask
  task automatic reset_log();
    exp_d.delete(); exp_c.delete(); got_d.delete(); got_c.delete(); fcnt_q.delete();
    fd_prev = 1'b0; fd_n = 0; fd_ov_bad = 0;
  endtask
  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    reset_log();
  endtask
  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    n_cmp++; if (frame_err_cnt !== '0) begin n_bad++; $display("FAIL reset_frame_err_cnt got=%0d exp=0", frame_err_cnt); end
    n_cmp++; if ({out_data, out_corrected} !== 12'h0) begin n_bad++; $display("FAIL reset_data got=%h/%b exp=0/0", out_data, out_corrected); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL post_reset_hs got=%b exp=01", {out_valid, in_ready}); end
  endtask
  task automatic test_decode();
    logic [14:0] codes[3];
    logic [10:0] ds[3];
    logic cs[3];
    logic a;
    codes = '{15'h7FFF, 15'h7FFB, 15'h0040};
    ds = '{11'h7FF, 11'h7FF, 11'h000};
    cs = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_clear();
      tick(1'b1, codes[i], ds[i], cs[i], 1'b1, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL decode_accept[%0d] got=%b exp=1", i, a); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL decode_early_valid[%0d] got=%b exp=0", i, out_valid); end
      tick(1'b0, '0, '0, 1'b0, 1'b1, a);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL decode_latency[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (out_data !== ds[i]) begin n_bad++; $display("FAIL decode_data[%0d] got=%h exp=%h", i, out_data, ds[i]); end
      n_cmp++; if (out_corrected !== cs[i]) begin n_bad++; $display("FAIL decode_corr[%0d] got=%b exp=%b", i, out_corrected, cs[i]); end
    end
  endtask
  task automatic test_frame();
    logic [14:0] w[4];
    logic [10:0] ds[4];
    logic cs[4];
    logic a, found;
    w = '{15'h7FFF, 15'h7FFB, 15'h0000, 15'h0001};
    ds = '{11'h7FF, 11'h7FF, 11'h000, 11'h000};
    cs = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_clear();
    for (int i = 0; i < 4; i++) tick(1'b1, w[i], ds[i], cs[i], 1'b1, a);
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, a);
      found = frame_done;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL frame_done_seen got=%b exp=1", found); end
    n_cmp++; if (got_d.size() != 4) begin n_bad++; $display("FAIL frame_hs_count got=%0d exp=4", got_d.size()); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL frame_report_valid got=%b exp=0", out_valid); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_cmp++; if ({got_d[i], got_c[i]} !== {ds[i], cs[i]}) begin n_bad++; $display("FAIL frame_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_c[i], ds[i], cs[i]); end
    end
    tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_pulse_width got=%b exp=0", frame_done); end
    n_cmp++; if (fcnt_q.size() != 1 || fcnt_q[0] !== 2'd2) begin n_bad++; $display("FAIL frame_err_cnt got=%0d exp=2", frame_err_cnt); end
  endtask
  task automatic test_saturation();
    logic [14:0] c;
    logic [10:0] d;
    logic e, a;
    do_clear();
    for (int i = 0; i < 4; i++) begin rand_word(1'b1, c, d, e); tick(1'b1, c, d, e, 1'b1, a); end
    for (int t = 0; t < 12 && fcnt_q.size() == 0; t++) tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if (fcnt_q.size() != 1 || fcnt_q[0] !== 2'd3) begin n_bad++; $display("FAIL sat_frame_err_cnt got=%0d exp=3", frame_err_cnt); end
    n_cmp++; if (frame_err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold got=%0d exp=3", frame_err_cnt); end
  endtask
  task automatic test_backpressure();
    logic [14:0] c;
    logic [10:0] d, held;
    logic e, a, ov;
    do_clear();
    for (int i = 0; i < 3; i++) begin rand_word(1'b0, c, d, e); tick(1'b1, c, d, e, 1'b1, a); end
    for (int i = 0; i < 5; i++) begin
      ov = out_valid;
      held = out_data;
      rand_word(1'b0, c, d, e);
      tick(1'b1, c, d, e, 1'b0, a);
      if (i >= 2) begin
        n_cmp++; if (ir_seen !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, ir_seen); end
      end
      if (ov) begin
        n_cmp++; if ({out_valid, out_data} !== {1'b1, held}) begin n_bad++; $display("FAIL bp_stable[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, held); end
      end
    end
    for (int i = 0; i < 6; i++) begin rand_word(1'b0, c, d, e); tick(1'b1, c, d, e, 1'b1, a); end
    for (int t = 0; t < 40 && got_d.size() < exp_d.size(); t++) tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if ({got_d[i], got_c[i]} !== {exp_d[i], exp_c[i]}) begin n_bad++; $display("FAIL bp_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_c[i], exp_d[i], exp_c[i]); end
    end
  endtask
  task automatic test_random();
    logic [14:0] c;
    logic [10:0] d;
    logic e, a;
    int s, nf;
    do_clear();
    for (int i = 0; i < 300; i++) begin
      rand_word(1'b0, c, d, e);
      tick($urandom_range(0, 9) < 7, c, d, e, $urandom_range(0, 9) < 7, a);
    end
    for (int t = 0; t < 60 && got_d.size() < exp_d.size(); t++) tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    for (int t = 0; t < 3; t++) tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      n_cmp++; if ({got_d[i], got_c[i]} !== {exp_d[i], exp_c[i]}) begin n_bad++; $display("FAIL rand_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_c[i], exp_d[i], exp_c[i]); end
    end
    nf = exp_c.size() / FL;
    n_cmp++; if (fcnt_q.size() != nf) begin n_bad++; $display("FAIL rand_frames got=%0d exp=%0d", fcnt_q.size(), nf); end
    n_cmp++; if (fd_ov_bad != 0) begin n_bad++; $display("FAIL rand_report_valid got=%0d exp=0", fd_ov_bad); end
    for (int f = 0; f < nf && f < fcnt_q.size(); f++) begin
      s = 0;
      for (int j = 0; j < FL; j++) if (exp_c[f*FL+j] && s < (1 << CW) - 1) s++;
      n_cmp++; if (int'(fcnt_q[f]) != s) begin n_bad++; $display("FAIL rand_frame_cnt[%0d] got=%0d exp=%0d", f, fcnt_q[f], s); end
    end
  endtask
`ifdef HAMMING_ERR_INJECT_EN
  task automatic test_inject();
    logic a;
    do_clear();
    inj_en = 1'b1;
    inj_pos = 4'd15;
    tick(1'b1, 15'h0000, 11'h000, 1'b1, 1'b1, a);
    inj_en = 1'b0;
    inj_pos = 4'd0;
    tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if ({out_valid, out_data, out_corrected} !== {1'b1, 11'h000, 1'b1}) begin n_bad++; $display("FAIL inject got=%b/%h/%b exp=1/000/1", out_valid, out_data, out_corrected); end
  endtask
`endif
  task automatic test_reset_midstream();
    logic [14:0] c;
    logic [10:0] d;
    logic e, a;
    do_clear();
    for (int i = 0; i < 4; i++) begin rand_word(1'b1, c, d, e); tick(1'b1, c, d, e, 1'b1, a); end
    for (int t = 0; t < 12 && fcnt_q.size() == 0; t++) tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    for (int i = 0; i < 3; i++) begin rand_word(1'b0, c, d, e); tick(1'b1, c, d, e, 1'b0, a); end
    n_cmp++; if ({out_valid, ir_seen, frame_err_cnt} !== {1'b1, 1'b0, 2'd3}) begin n_bad++; $display("FAIL rst_pre got=%b/%b/%0d exp=1/0/3", out_valid, ir_seen, frame_err_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready, frame_done} !== 3'b010) begin n_bad++; $display("FAIL rst_mid_hs got=%b exp=010", {out_valid, in_ready, frame_done}); end
    n_cmp++; if (frame_err_cnt !== '0) begin n_bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", frame_err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    reset_log();
    d = 11'h2A5;
    tick(1'b1, encode(d), d, 1'b0, 1'b1, a);
    tick(1'b0, '0, '0, 1'b0, 1'b1, a);
    n_cmp++; if ({out_valid, out_data, out_corrected} !== {1'b1, d, 1'b0}) begin n_bad++; $display("FAIL rst_recover got=%b/%h/%b exp=1/%h/0", out_valid, out_data, out_corrected, d); end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_decode();
    test_frame();
    test_saturation();
    test_backpressure();
    test_random();
`ifdef HAMMING_ERR_INJECT_EN
    test_inject();
`endif
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
